uart_tx_frame_gen: RTL and testbench



---
 rtl/uart_tx_frame_gen.sv | 107 ++++++++++
 tb/tb_uart_tx_frame_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: one bit per CLK cycle, frame = start, LSB-first data, optional parity, stop.
// Frames can run back-to-back when a new word is accepted during the stop bit.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int BIT_CNT_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                   state_reg;
    logic [DATA_WIDTH-1:0]    shift_reg;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_reg;
    logic                     par_en_reg;
    logic                     parity_reg;
    logic                     tx_out_reg;
    logic                     busy_reg;
    logic                     accept;

    // A new word may only be taken while idle or during the stop bit.
    assign accept = DATA_VALID && ((state_reg == IDLE) || (state_reg == STOP));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            par_en_reg  <= 1'b0;
            parity_reg  <= 1'b0;
            tx_out_reg  <= 1'b1;
            busy_reg    <= 1'b0;
        end else if (accept) begin
            shift_reg   <= P_DATA;
            par_en_reg  <= PAR_EN;
            parity_reg  <= (^P_DATA) ^ PAR_TYP;
            bit_cnt_reg <= '0;
            state_reg   <= START;
            tx_out_reg  <= 1'b0;
            busy_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_out_reg <= 1'b1;
                    busy_reg   <= 1'b0;
                end
                START: begin
                    state_reg   <= DATA;
                    bit_cnt_reg <= '0;
                    tx_out_reg  <= shift_reg[0];
                    busy_reg    <= 1'b1;
                end
                DATA: begin
                    busy_reg <= 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        if (par_en_reg) begin
                            state_reg  <= PARITY;
                            tx_out_reg <= parity_reg;
                        end else begin
                            state_reg  <= STOP;
                            tx_out_reg <= 1'b1;
                        end
                    end else begin
                        // Shift so that bit 1 is always the next data bit to send.
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        shift_reg   <= shift_reg >> 1;
                        tx_out_reg  <= shift_reg[1];
                    end
                end
                PARITY: begin
                    state_reg  <= STOP;
                    tx_out_reg <= 1'b1;
                    busy_reg   <= 1'b1;
                end
                STOP: begin
                    state_reg  <= IDLE;
                    tx_out_reg <= 1'b1;
                    busy_reg   <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    tx_out_reg <= 1'b1;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_out_reg;
    assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: directed scenarios plus random traffic, checked every cycle
// against a queue of expected line symbols built from the frame format.
module tb_uart_tx_frame_gen;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          BUSY;

    uart_tx_frame_gen #(.DATA_WIDTH(DW), .BIT_CNT_WIDTH(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic tx;
        logic busy;
        logic last;
    } item_t;

    localparam item_t IDLE_ITEM = '{tx: 1'b1, busy: 1'b0, last: 1'b0};

    item_t       exp_q[$];
    item_t       cur = IDLE_ITEM;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] tx_hist = '0;
    logic [9:0]  a5_frame;

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        int ones;
        ones = 0;
        exp_q.push_back('{tx: 1'b0, busy: 1'b1, last: 1'b0});
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back('{tx: d[i], busy: 1'b1, last: 1'b0});
            ones += int'(d[i]);
        end
        if (pe)
            exp_q.push_back('{tx: ((ones % 2) == 1) ^ pt, busy: 1'b1, last: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, last: 1'b1});
    endtask

    // Advance one clock: update the reference with the inputs the DUT will sample, then compare.
    task automatic cycle(input string tag);
        if (!RST) begin
            exp_q.delete();
            cur = IDLE_ITEM;
        end else begin
            if (DATA_VALID && (!cur.busy || cur.last))
                push_frame(P_DATA, PAR_EN, PAR_TYP);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = IDLE_ITEM;
        end
        @(posedge CLK);
        #1;
        tx_hist = {tx_hist[30:0], TX_OUT};
        n_checks++;
        assert (TX_OUT === cur.tx) else begin
            n_fail++;
            $error("FAIL %s tx: got %b expected %b", tag, TX_OUT, cur.tx);
        end
        n_checks++;
        assert (BUSY === cur.busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b expected %b", tag, BUSY, cur.busy);
        end
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // Reset and idle line
        cycles(3, "reset");
        RST = 1'b1;
        cycles(10, "idle");

        // 0xA5, no parity; also compare the captured frame against the literal bit sequence
        P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        cycle("a5_nopar");
        DATA_VALID = 1'b0;
        cycles(9, "a5_nopar");
        a5_frame = tx_hist[9:0];
        n_checks++;
        assert (a5_frame === 10'b0101001011) else begin
            n_fail++;
            $error("FAIL a5_frame_bits: got %b expected %b", a5_frame, 10'b0101001011);
        end
        cycles(3, "a5_nopar_tail");

        // 0xA5, even parity
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        cycle("a5_even");
        DATA_VALID = 1'b0;
        cycles(13, "a5_even");

        // 0x01, odd parity
        P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        cycle("01_odd");
        DATA_VALID = 1'b0;
        cycles(13, "01_odd");

        // Masking: request during DATA phase must be ignored
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        cycle("mask");
        DATA_VALID = 1'b0;
        cycles(3, "mask");
        P_DATA = 8'hFF; PAR_EN = 1'b1; DATA_VALID = 1'b1;
        cycle("mask_pulse");
        DATA_VALID = 1'b0; PAR_EN = 1'b0;
        cycles(12, "mask_tail");

        // Back-to-back with DATA_VALID held high, data changed during first stop bit
        P_DATA = 8'h55; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        cycles(10, "b2b_first");
        P_DATA = 8'hAA;
        cycle("b2b_edge");
        DATA_VALID = 1'b0;
        cycles(12, "b2b_second");

        // Reset in the middle of a frame at data bit 4
        P_DATA = 8'h00; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        cycle("rst_mid");
        DATA_VALID = 1'b0;
        cycles(5, "rst_mid");
        RST = 1'b0;
        cycle("rst_mid_assert");
        RST = 1'b1;
        cycles(12, "rst_mid_after");

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            RST        = ($urandom_range(0, 99) != 0);
            DATA_VALID = ($urandom_range(0, 3) == 0);
            P_DATA     = DW'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            cycle("random");
        end
        RST = 1'b1; DATA_VALID = 1'b0;
        cycles(14, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
